// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared opcode encodings, legality check and sequencer FSM state |
// |            encoding for the ALU command sequencer.                         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

   // ALU opcodes
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_LS   = 3'd1;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_XOR  = 3'd3;
   localparam logic [2:0] ALU_CMP  = 3'd4;
   localparam logic [2:0] ALU_IDLE = 3'd7;

   // Sequencer FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= ALU_CMP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_cmd_sequencer_if                                            |
// | Purpose  : Bundles the command, ALU-drive and response channels of the     |
// |            ALU command sequencer.                                          |
// | Ports    : cmd_* (command in), alu_* (ALU operands/opcode out, result in), |
// |            rsp_* (response out), busy.                                     |
// |            modport slave  : the sequencer                                  |
// |            modport master : the environment (command source, ALU, sink)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface alu_cmd_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_a;
   logic [DATA_W-1:0] cmd_b;
   logic [OP_W-1:0]   cmd_op;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_choice;
   logic [DATA_W-1:0] alu_result;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [OP_W-1:0]   rsp_op;
   logic              rsp_err;

   logic              busy;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_choice,
      output rsp_valid, rsp_data, rsp_op, rsp_err, busy
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_choice,
      input  rsp_valid, rsp_data, rsp_op, rsp_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_cmd_fifo                                                    |
// | Purpose  : Synchronous DEPTH x WIDTH FIFO holding packed {a, b, op}        |
// |            commands. Head entry is presented combinationally on rd_data.  |
// | Ports    : clk, rst (async high), push/wr_data, pop/rd_data,               |
// |            full, empty, count                                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_cmd_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             push,
   input  wire logic [WIDTH-1:0] wr_data,
   input  wire logic             pop,
   output logic      [WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic      [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Guard against overflow/underflow regardless of caller behaviour
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read when count says valid
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_cmd_sequencer                                               |
// | Purpose  : Buffers {a, b, op} commands, drives them one at a time into a   |
// |            combinational ALU, captures the result and returns             |
// |            {result, op, err}. An IDLE opcode is always driven between     |
// |            commands so the ALU's choice input changes every command.      |
// | Ports    : clk, rst (async high), bus (alu_cmd_sequencer_if.slave)         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3,
   parameter int DEPTH  = 4
) (
   input wire logic          clk,
   input wire logic          rst,
   alu_cmd_sequencer_if.slave bus
);

   localparam int FE_W = 2*DATA_W + OP_W;
   localparam int AW   = $clog2(DEPTH);

   logic [FE_W-1:0]   fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [AW:0]       fifo_count;
   logic              fifo_push;
   logic              fifo_pop;
   logic [DATA_W-1:0] head_a;
   logic [DATA_W-1:0] head_b;
   logic [OP_W-1:0]   head_op;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [OP_W-1:0]   alu_choice_q, alu_choice_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
   logic              rsp_err_q, rsp_err_d;

   // cmd_ready is held low throughout reset so nothing is accepted then
   assign bus.cmd_ready = !fifo_full && !rst;
   assign fifo_push     = bus.cmd_valid && bus.cmd_ready;
   assign fifo_pop      = (state_q == ST_IDLE) && !fifo_empty;

   assign head_a  = fifo_head[FE_W-1 -: DATA_W];
   assign head_b  = fifo_head[OP_W +: DATA_W];
   assign head_op = fifo_head[OP_W-1:0];

   alu_cmd_fifo #(
      .WIDTH (FE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .wr_data ({bus.cmd_a, bus.cmd_b, bus.cmd_op}),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!fifo_empty)   state_d = ST_LOAD;
         ST_LOAD:                    state_d = ST_RESP;
         ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // Output-register next values
   always_comb begin
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_choice_d = alu_choice_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_op_d     = rsp_op_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            alu_choice_d = ALU_IDLE;
            if (!fifo_empty) begin
               alu_a_d  = head_a;
               alu_b_d  = head_b;
               rsp_op_d = head_op;
               // Illegal opcodes never reach the ALU choice input
               if (is_legal_op(head_op)) alu_choice_d = head_op;
            end
         end
         ST_LOAD: begin
            rsp_data_d   = is_legal_op(rsp_op_q) ? bus.alu_result : '0;
            rsp_err_d    = !is_legal_op(rsp_op_q);
            rsp_valid_d  = 1'b1;
            alu_choice_d = ALU_IDLE;
         end
         ST_RESP: begin
            if (bus.rsp_ready) rsp_valid_d = 1'b0;
         end
         default: begin
            alu_choice_d = ALU_IDLE;
            rsp_valid_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_choice_q <= ALU_IDLE;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_op_q     <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_choice_q <= alu_choice_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_op_q     <= rsp_op_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_choice = alu_choice_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_op     = rsp_op_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.busy       = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_cmd_sequencer                                            |
// | Purpose  : Self-checking bench for alu_cmd_sequencer. Directed commands    |
// |            push hand-computed responses into a queue; a negedge monitor    |
// |            pops and compares on every accepted response. Includes a small |
// |            combinational ALU model to close the loop.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_cmd_sequencer;

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] op;
      logic       err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_cmd_sequencer_if #(.DATA_W(8), .OP_W(3)) bus ();

   alu_cmd_sequencer #(.DATA_W(8), .OP_W(3), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Environment ALU; unknown choice codes give a marker value
   always_comb begin
      case (bus.alu_choice)
         3'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
         3'd1:    bus.alu_result = bus.alu_a << 1;
         3'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
         3'd3:    bus.alu_result = bus.alu_a ^ bus.alu_b;
         3'd4:    bus.alu_result = {7'd0, (bus.alu_a > bus.alu_b)};
         default: bus.alu_result = 8'hEE;
      endcase
   end

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Response monitor: compares on handshake, checks stability while stalled
   logic       held = 1'b0;
   logic [7:0] held_d;
   logic [2:0] held_op;
   logic       held_err;
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else if (bus.rsp_valid) begin
         if (!bus.rsp_ready) begin
            if (held) begin
               check("hold_data", bus.rsp_data, held_d);
               check("hold_op",   bus.rsp_op,   held_op);
               check("hold_err",  bus.rsp_err,  held_err);
            end
            held     = 1'b1;
            held_d   = bus.rsp_data;
            held_op  = bus.rsp_op;
            held_err = bus.rsp_err;
         end else begin
            exp_t e;
            held = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp actual=%0h required=none", bus.rsp_data);
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", bus.rsp_data, e.d);
               check("rsp_op",   bus.rsp_op,   e.op);
               check("rsp_err",  bus.rsp_err,  e.err);
            end
         end
      end else begin
         held = 1'b0;
      end
   end

   // Choice-history recorder and illegal-op watch
   logic       rec   = 1'b0;
   logic       watch = 1'b0;
   int         bad_choice = 0;
   logic [2:0] hist[$];
   always @(negedge clk) begin
      if (rec && (hist.size() == 0 || hist[$] != bus.alu_choice))
         hist.push_back(bus.alu_choice);
      if (watch && bus.alu_choice != 3'd7) bad_choice++;
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] d, input logic err);
      int t = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_op    = op;
      while (!bus.cmd_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=%0d required=<200", t);
      end else begin
         exp_q.push_back('{d: d, op: op, err: err});
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while ((bus.busy || bus.rsp_valid) && t < 300);
      if (t >= 300) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=%0d required=<300", t);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] t4_a  [6];
   logic [7:0] t4_b  [6];
   logic [2:0] t4_op [6];
   logic [7:0] t4_d  [6];
   logic [2:0] hexp  [5];

   initial begin
      int t;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_op    = '0;
      bus.rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_alu_choice", bus.alu_choice, 3'd7);
      check("rst_alu_a",      bus.alu_a,      8'h00);
      check("rst_alu_b",      bus.alu_b,      8'h00);
      check("rst_rsp_valid",  bus.rsp_valid,  1'b0);
      check("rst_rsp_data",   bus.rsp_data,   8'h00);
      check("rst_rsp_op",     bus.rsp_op,     3'd0);
      check("rst_rsp_err",    bus.rsp_err,    1'b0);
      check("rst_busy",       bus.busy,       1'b0);
      check("rst_cmd_ready",  bus.cmd_ready,  1'b0);
      rst = 1'b0;
      #1;
      check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
      @(posedge clk); #1;

      // 1: latency and choice timing of a single ADD
      send(8'h0F, 8'h01, 3'd0, 8'h10, 1'b0);
      @(negedge clk);
      check("t1_choice_n",   bus.alu_choice, 3'd7);
      check("t1_busy_n",     bus.busy,       1'b1);
      @(negedge clk);
      check("t1_choice_n1",  bus.alu_choice, 3'd0);
      check("t1_valid_n1",   bus.rsp_valid,  1'b0);
      check("t1_alu_a_n1",   bus.alu_a,      8'h0F);
      @(negedge clk);
      check("t1_valid_n2",   bus.rsp_valid,  1'b1);
      check("t1_choice_n2",  bus.alu_choice, 3'd7);
      wait_idle();

      // 2: arithmetic boundaries
      send(8'hFF, 8'h01, 3'd0, 8'h00, 1'b0);
      send(8'h80, 8'h7F, 3'd4, 8'h01, 1'b0);
      send(8'h7F, 8'h80, 3'd4, 8'h00, 1'b0);
      send(8'hC1, 8'h00, 3'd1, 8'h82, 1'b0);
      wait_idle();

      // 3: back-to-back identical opcodes still toggle choice through IDLE
      hist.delete();
      rec = 1'b1;
      send(8'hAA, 8'h0F, 3'd3, 8'hA5, 1'b0);
      send(8'hF0, 8'hFF, 3'd3, 8'h0F, 1'b0);
      wait_idle();
      rec = 1'b0;
      hexp[0] = 3'd7; hexp[1] = 3'd3; hexp[2] = 3'd7; hexp[3] = 3'd3; hexp[4] = 3'd7;
      check("t3_hist_len", hist.size(), 5);
      for (int i = 0; i < hist.size() && i < 5; i++)
         check($sformatf("t3_hist_%0d", i), hist[i], hexp[i]);

      // 4: backpressure fills FIFO; sixth push refused
      t4_a[0] = 8'h10; t4_b[0] = 8'h20; t4_op[0] = 3'd0; t4_d[0] = 8'h30;
      t4_a[1] = 8'hF0; t4_b[1] = 8'h3C; t4_op[1] = 3'd2; t4_d[1] = 8'h30;
      t4_a[2] = 8'h55; t4_b[2] = 8'hFF; t4_op[2] = 3'd3; t4_d[2] = 8'hAA;
      t4_a[3] = 8'h41; t4_b[3] = 8'h00; t4_op[3] = 3'd1; t4_d[3] = 8'h82;
      t4_a[4] = 8'h03; t4_b[4] = 8'h02; t4_op[4] = 3'd4; t4_d[4] = 8'h01;
      t4_a[5] = 8'h01; t4_b[5] = 8'h01; t4_op[5] = 3'd0; t4_d[5] = 8'h02;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_a     = t4_a[i];
         bus.cmd_b     = t4_b[i];
         bus.cmd_op    = t4_op[i];
         check($sformatf("t4_cmd_ready_%0d", i), bus.cmd_ready, (i < 5) ? 1'b1 : 1'b0);
         if (bus.cmd_ready) exp_q.push_back('{d: t4_d[i], op: t4_op[i], err: 1'b0});
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t4_still_full", bus.cmd_ready, 1'b0);
      check("t4_busy",       bus.busy,      1'b1);
      check("t4_rsp_valid",  bus.rsp_valid, 1'b1);
      bus.rsp_ready = 1'b1;
      wait_idle();
      check("t4_queue_drained", exp_q.size(), 0);

      // 5: illegal opcode never reaches the ALU choice input
      bad_choice = 0;
      watch = 1'b1;
      send(8'h12, 8'h34, 3'd6, 8'h00, 1'b1);
      wait_idle();
      watch = 1'b0;
      check("t5_choice_stuck_idle", bad_choice, 0);

      // 6: async reset in the middle of RESP
      bus.rsp_ready = 1'b0;
      send(8'h05, 8'h06, 3'd0, 8'h0B, 1'b0);
      t = 0;
      while (!bus.rsp_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("t6_reached_resp", bus.rsp_valid, 1'b1);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("t6_rsp_valid",  bus.rsp_valid,  1'b0);
      check("t6_busy",       bus.busy,       1'b0);
      check("t6_alu_choice", bus.alu_choice, 3'd7);
      check("t6_rsp_data",   bus.rsp_data,   8'h00);
      check("t6_cmd_ready",  bus.cmd_ready,  1'b0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      #1;
      check("t6_cmd_ready_rel", bus.cmd_ready, 1'b1);
      @(posedge clk); #1;
      send(8'h01, 8'h02, 3'd0, 8'h03, 1'b0);
      wait_idle();
      check("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the 8-bit combinational ALU.
- Accepts {a, b, op} commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU operand and opcode inputs one command at a time, captures the ALU result, and returns {result, op, err} on a valid/ready response interface.
- Guarantees an opcode change on the ALU's choice input between commands, because the ALU stage re-evaluates only when its opcode input changes.

Parameters:
- DATA_W, 8: operand/result width.
- OP_W, 3: opcode width.
- DEPTH, 4: command FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_a  in  DATA_W  operand a.
- cmd_b  in  DATA_W  operand b.
- cmd_op  in  OP_W  opcode.
- alu_a  out  DATA_W  registered operand a to ALU.
- alu_b  out  DATA_W  registered operand b to ALU.
- alu_choice  out  OP_W  registered opcode to ALU.
- alu_result  in  DATA_W  ALU output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  downstream accepts response.
- rsp_data  out  DATA_W  captured result.
- rsp_op  out  OP_W  opcode of this response.
- rsp_err  out  1  illegal opcode flag.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset (async, immediate), values held while rst=1:
  - FIFO emptied; FSM=IDLE.
  - alu_a=0, alu_b=0, alu_choice=3'b111 (IDLE code).
  - rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0.
  - busy=0; cmd_ready=0 while rst high, 1 after release.
  - An in-flight command or unconsumed response is discarded.
- Opcodes: ADD=0, LS=1, AND=2, XOR=3, CMP=4 are legal; 5, 6, 7 are illegal.
- Command push: on edge with cmd_valid && cmd_ready. cmd_ready = !full, combinational from count. No bypass when full.
- Simultaneous push and pop: count unchanged, pointers both advance.
- FSM:
  - IDLE:
    - alu_choice=3'b111.
    - If FIFO non-empty: pop, load alu_a/alu_b/alu_choice from the head entry (illegal op: alu_choice stays 3'b111, operands loaded), latch op into rsp_op, go LOAD.
    - Else stay.
  - LOAD:
    - One cycle; ALU settles on the registered inputs.
    - At the edge: rsp_data <= legal ? alu_result : 0; rsp_err <= !legal; rsp_valid <= 1; alu_choice <= 3'b111; go RESP.
  - RESP:
    - Hold rsp_* stable while rsp_valid && !rsp_ready.
    - On edge with rsp_ready: rsp_valid <= 0, go IDLE.
- Latency: with FSM idle and FIFO empty, a command accepted at edge N gives rsp_valid=1 after edge N+2.
- Throughput: one response per 3 cycles minimum (IDLE, LOAD, RESP). The IDLE cycle is the mandatory 3'b111 gap, so identical consecutive opcodes still produce a choice transition.
- Arithmetic: result width DATA_W; ADD overflow truncates (carry dropped); CMP result is 8'h01 or 8'h00, unsigned.
- Order: responses are strictly in command order.
- busy = (count != 0) || (state != IDLE).

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams ALU_ADD=3'd0, ALU_LS=3'd1, ALU_AND=3'd2, ALU_XOR=3'd3, ALU_CMP=3'd4, ALU_IDLE=3'd7.
  - The is_legal_op function (op <= 4).
  - FSM state encoding IDLE/LOAD/RESP.
- Sub-module alu_cmd_fifo: synchronous FIFO, DEPTH x (2*DATA_W+OP_W), with push/pop/full/empty/count and async reset.
- Sequencer top holds the FSM plus the output registers.

Test Plan:
1. Idle block, push ADD a=8'h0F b=8'h01 at edge N, rsp_ready=1 -> alu_choice=0 after N+1; rsp_valid=1 after N+2 with rsp_data=8'h10, rsp_op=0, rsp_err=0; alu_choice back to 3'b111 after N+2.
2. ADD 8'hFF+8'h01 -> rsp_data=8'h00. CMP a=8'h80 b=8'h7F -> 8'h01. CMP a=8'h7F b=8'h80 -> 8'h00. LS a=8'hC1 -> 8'h82.
3. Two consecutive XOR commands (8'hAA^8'h0F, then 8'hF0^8'hFF) -> 8'hA5 then 8'h0F; alu_choice shows 3 -> 7 -> 3 between them.
4. rsp_ready=0, push on 6 consecutive cycles -> 5 accepted (4 in FIFO, 1 in flight), cmd_ready=0 on the 6th. rsp_* held stable. After rsp_ready=1, 5 responses return in order.
5. Push op=3'b110 a=8'h12 b=8'h34 -> rsp_data=8'h00, rsp_err=1, rsp_op=3'b110; alu_choice never leaves 3'b111.
6. Assert rst mid-RESP between clock edges -> rsp_valid, busy and count go to 0 and alu_choice to 3'b111 without waiting for an edge. After release, a new ADD 1+2 returns 8'h03.
